// File: rtl/bridge_pkg.sv
// Shared definitions for the PC <-> FPGA2 bridge: FSM state encodings,
// default timeout reply word and a saturating counter helper.
package bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LSEND  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_HSEND  = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    // Widest block width for which the default error word is defined.
    localparam int unsigned ERR_WORD_MAX_W = 1024;
    // Reply sent to the host when FPGA2 never answers; sliced to DW by the top.
    localparam logic [ERR_WORD_MAX_W-1:0] ERR_WORD_DEFAULT = '1;

    // 8-bit increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO holding host blocks until the bridge FSM forwards them.
// DEPTH must be a power of two (pointers wrap naturally). A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module cmd_fifo #(
    parameter  int unsigned DW    = 128,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      level_d = level_q + 1'b1;
        else if (!do_push && do_pop) level_d = level_q - 1'b1;
    end

    // Pointer/occupancy registers; clearing these empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/pc_fpga_bridge.sv
// PC <-> FPGA2 bridge: queues host blocks, forwards each one over the link,
// waits for the FPGA2 reply and returns it to the host, one command at a time.
// Optional feature macro: BRIDGE_TIMEOUT_EN -- abandons a link wait after
// TMO_CYC cycles and answers the host with ERR_WORD instead.
module pc_fpga_bridge
    import bridge_pkg::*;
#(
    parameter int unsigned    DW       = 128,
    parameter int unsigned    DEPTH    = 4,
    parameter int unsigned    TMO_CYC  = 1_000_000,
    parameter logic [DW-1:0]  ERR_WORD = ERR_WORD_DEFAULT[DW-1:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   host_rx_valid,
    input  logic [DW-1:0]          host_rx_data,
    output logic                   host_tx_start,
    output logic [DW-1:0]          host_tx_data,
    input  logic                   host_tx_busy,
    output logic                   link_send,
    output logic [DW-1:0]          link_tx_data,
    input  logic                   link_rx_ok,
    input  logic [DW-1:0]          link_rx_data,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [7:0]             drop_cnt,
    output logic [7:0]             tmo_cnt,
    output logic [2:0]             state_o
);

    state_e        state_q, state_d;
    logic [DW-1:0] link_data_q, link_data_d;
    logic [DW-1:0] host_data_q, host_data_d;
    logic [7:0]    drop_q, drop_d;

    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rdata;

    cmd_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (host_rx_valid),
        .wdata_i (host_rx_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

`ifdef BRIDGE_TIMEOUT_EN
    localparam int unsigned     TW       = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(TMO_CYC - 1);

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    tmo_q, tmo_d;

    assign tmo_cnt = tmo_q;
`else
    assign tmo_cnt = '0;

    // Timeout parameters have no function in this build.
    logic unused_cfg;
    assign unused_cfg = (^ERR_WORD) ^ (TMO_CYC == 0);
`endif

    assign link_send     = (state_q == ST_LSEND);
    assign host_tx_start = (state_q == ST_HSEND);
    assign link_tx_data  = link_data_q;
    assign host_tx_data  = host_data_q;
    assign drop_cnt      = drop_q;
    assign state_o       = state_q;

    // A host block is lost only when the FIFO is full and nothing leaves it this cycle.
    always_comb begin
        drop_d = drop_q;
        if (host_rx_valid && fifo_full && !fifo_pop) drop_d = sat_inc8(drop_q);
    end

    // Transaction FSM: next state, FIFO pop and reply/forward data capture.
    always_comb begin
        state_d     = state_q;
        link_data_d = link_data_q;
        host_data_d = host_data_q;
        fifo_pop    = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
        tcnt_d      = tcnt_q;
        tmo_d       = tmo_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !host_tx_busy) begin
                    fifo_pop    = 1'b1;
                    link_data_d = fifo_rdata;
                    state_d     = ST_LSEND;
                end
            end
            ST_LSEND: begin
`ifdef BRIDGE_TIMEOUT_EN
                tcnt_d  = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A real reply wins over a timeout expiring in the same cycle.
                if (link_rx_ok) begin
                    host_data_d = link_rx_data;
                    state_d     = ST_HSEND;
                end
`ifdef BRIDGE_TIMEOUT_EN
                else if (tcnt_q == TMO_LAST) begin
                    host_data_d = ERR_WORD;
                    tmo_d       = sat_inc8(tmo_q);
                    state_d     = ST_HSEND;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
`endif
            end
            ST_HSEND: begin
                state_d = ST_FINISH;
            end
            ST_FINISH: begin
                if (!host_tx_busy) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            link_data_q <= '0;
            host_data_q <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            link_data_q <= link_data_d;
            host_data_q <= host_data_d;
            drop_q      <= drop_d;
        end
    end

`ifdef BRIDGE_TIMEOUT_EN
    // WAIT-cycle counter and timeout statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt_q <= '0;
            tmo_q  <= '0;
        end else begin
            tcnt_q <= tcnt_d;
            tmo_q  <= tmo_d;
        end
    end
`endif

endmodule

// File: doc/pc_fpga_bridge.md
PC_FPGA_BRIDGE -- requirements
Module: pc_fpga_bridge

Interface
REQ-001 SHALL have parameter DW, default 128, meaning block width carried host<->link.
REQ-002 SHALL have parameter DEPTH, default 4, meaning command FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter TMO_CYC, default 1_000_000, meaning link response timeout in clk cycles.
REQ-004 SHALL have parameter ERR_WORD, default all-ones DW bits, meaning reply word sent to host on timeout.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on posedge.
REQ-006 SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port host_rx_valid, input, 1, meaning one-cycle pulse: a new host block is present.
REQ-008 SHALL have port host_rx_data, input, DW, meaning the host block, valid with host_rx_valid.
REQ-009 SHALL have port host_tx_start, output, 1, meaning one-cycle pulse: send host_tx_data to the host.
REQ-010 SHALL have port host_tx_data, output, DW, meaning the reply block, stable from start until the next start.
REQ-011 SHALL have port host_tx_busy, input, 1, meaning the host transmitter is busy.
REQ-012 SHALL have port link_send, output, 1, meaning one-cycle pulse: transmit link_tx_data to FPGA2.
REQ-013 SHALL have port link_tx_data, output, DW, meaning the block to FPGA2.
REQ-014 SHALL have port link_rx_ok, input, 1, meaning one-cycle pulse: FPGA2 reply is valid.
REQ-015 SHALL have port link_rx_data, input, DW, meaning the FPGA2 reply.
REQ-016 SHALL have port fifo_level, output, clog2(DEPTH)+1, meaning the current FIFO occupancy.
REQ-017 SHALL have port drop_cnt, output, 8, meaning a saturating count of host blocks dropped on full.
REQ-018 SHALL have port tmo_cnt, output, 8, meaning a saturating count of link timeouts.
REQ-019 SHALL have port state_o, output, 3, meaning the current FSM state encoding.

Function
REQ-020 SHALL push host_rx_data on host_rx_valid when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-021 SHALL drop host_rx_valid when the FIFO is full with no pop in the same cycle, and increment drop_cnt, saturating at 255.
REQ-022 SHALL implement FSM states IDLE=0, LSEND=1, WAIT=2, HSEND=3, FINISH=4.
REQ-023 SHALL, in IDLE with the FIFO non-empty and host_tx_busy=0, pop the head into link_tx_data and go to LSEND.
REQ-024 SHALL, in LSEND, assert link_send for exactly one cycle and go to WAIT.
REQ-025 SHALL, in WAIT on link_rx_ok, latch link_rx_data into host_tx_data and go to HSEND.
REQ-026 SHALL ignore link_rx_ok pulses outside WAIT, with no state or data change.
REQ-027 SHALL, in HSEND, assert host_tx_start for exactly one cycle and go to FINISH.
REQ-028 SHALL hold FINISH for at least one cycle, then go to IDLE on the first cycle with host_tx_busy=0.
REQ-029 SHALL assert link_send exactly 2 cycles after host_rx_valid when the FSM is IDLE, the FIFO is empty and host_tx_busy=0.
REQ-030 SHALL give link_rx_ok priority over a timeout expiring in the same cycle.
REQ-031 SHALL process commands strictly in FIFO order, with exactly one link transaction per command.

Reset
REQ-032 SHALL, on rst=0, asynchronously force the FSM to IDLE and clear the FIFO and all counters.
REQ-033 SHALL, on rst=0, drive link_send=0, host_tx_start=0, link_tx_data=0, host_tx_data=0, fifo_level=0 and state_o=0.
REQ-034 SHALL abandon any in-flight transaction on reset mid-operation, issuing no reply to the host.

Configuration
REQ-035 SHALL, with BRIDGE_TIMEOUT_EN defined, count cycles in WAIT; on reaching TMO_CYC it loads ERR_WORD into host_tx_data, increments tmo_cnt and goes to HSEND.
REQ-036 SHALL, without BRIDGE_TIMEOUT_EN, wait in WAIT indefinitely, remove the timeout counter, and tie tmo_cnt to 0.

Structure
REQ-037 SHALL define the FSM state encodings and the default ERR_WORD in shared package bridge_pkg.
REQ-038 SHALL implement the FIFO as sub-module cmd_fifo, parameterised by DW and DEPTH, with push, pop, full, empty and level ports.

Verification
REQ-039 SHALL cover: one host block 0x0123...CDEF with FPGA2 replying 0xA5A5...A5 after 50 cycles -> link_send at +2 cycles, then host_tx_start with the reply word.
REQ-040 SHALL cover: 6 back-to-back host pulses with DEPTH=4 and link stalled -> fifo_level=4, drop_cnt=1 (one entry already popped), replies in order.
REQ-041 SHALL cover: BRIDGE_TIMEOUT_EN defined, TMO_CYC=100, no link_rx_ok -> host_tx_start carries ERR_WORD after 100 WAIT cycles, tmo_cnt=1.
REQ-042 SHALL cover: link_rx_ok coincident with timeout expiry -> reply equals link_rx_data and tmo_cnt is unchanged.
REQ-043 SHALL cover: rst pulsed low during WAIT -> state_o=0, fifo_level=0, and no host_tx_start afterwards.
REQ-044 SHALL cover: host_tx_busy held high for 20 cycles after start -> FSM stays in FINISH and the next link_send occurs only after busy falls.
